// File: rtl/tlp_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tlp_pkg : shared TLP header field widths, bit positions, fmt decode and   |
// |           the header-capture state encoding.                              |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
package tlp_pkg;

  localparam int c_fmt_w  = 3;
  localparam int c_type_w = 5;
  localparam int c_tc_w   = 3;
  localparam int c_attr_w = 2;
  localparam int c_len_w  = 10;
  localparam int c_be_w   = 4;

  // DW0 bit positions
  localparam int c_fmt_msb  = 31;
  localparam int c_fmt_lsb  = 29;
  localparam int c_type_msb = 28;
  localparam int c_type_lsb = 24;
  localparam int c_tc_msb   = 22;
  localparam int c_tc_lsb   = 20;
  localparam int c_td_bit   = 15;
  localparam int c_ep_bit   = 14;
  localparam int c_attr_msb = 13;
  localparam int c_attr_lsb = 12;
  localparam int c_len_lsb  = 0;

  // DW1 bit positions
  localparam int c_fbe_msb = 3;
  localparam int c_fbe_lsb = 0;
  localparam int c_lbe_msb = 7;
  localparam int c_lbe_lsb = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_HOLD    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DIGEST  = 3'd4,
    ST_DROP    = 3'd5
  } state_e;

  function automatic logic is_4dw(input logic [c_fmt_w-1:0] fmt);
    return (fmt & 3'b001) != 3'b000;
  endfunction

  function automatic logic has_data(input logic [c_fmt_w-1:0] fmt);
    return (fmt & 3'b010) != 3'b000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_hdr_capture.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tlp_hdr_capture : assembles a 3DW/4DW TLP header from the receive DW      |
// |                   stream, forwards payload, strips ECRC, flags framing.   |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module tlp_hdr_capture
  import tlp_pkg::*;
#(
  parameter int DW_W  = 32,
  parameter int LEN_W = c_len_w
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW_W-1:0]     in_data,
  input  logic                in_sop,
  input  logic                in_eop,
  output logic                hdr_valid,
  input  logic                hdr_ready,
  output logic [c_fmt_w-1:0]  hdr_fmt,
  output logic [c_type_w-1:0] hdr_type,
  output logic [c_tc_w-1:0]   hdr_tc,
  output logic                hdr_td,
  output logic                hdr_ep,
  output logic [c_attr_w-1:0] hdr_attr,
  output logic [LEN_W-1:0]    hdr_len,
  output logic [c_be_w-1:0]   hdr_first_be,
  output logic [c_be_w-1:0]   hdr_last_be,
  output logic [DW_W-1:0]     hdr_addr_hi,
  output logic [DW_W-3:0]     hdr_addr_lo,
  output logic                pl_valid,
  input  logic                pl_ready,
  output logic [DW_W-1:0]     pl_data,
  output logic                pl_last,
  output logic                err_malformed
);

  localparam logic [LEN_W:0] c_cnt_one  = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [LEN_W:0] c_cnt_max  = {1'b1, {LEN_W{1'b0}}};

  state_e                r_state;
  state_e                w_state_nxt;
  logic                  w_accept;
  logic                  w_err;
  logic                  w_hdr_last;
  logic                  w_cnt_one;

  logic                  r_in_ready;
  logic                  r_hdr_valid;
  logic                  r_err;
  logic                  r_err_done;
  logic                  r_eop_seen;
  logic [1:0]            r_hdr_idx;
  logic [LEN_W:0]        r_pl_cnt;

  logic [c_fmt_w-1:0]    r_fmt;
  logic [c_type_w-1:0]   r_type;
  logic [c_tc_w-1:0]     r_tc;
  logic                  r_td;
  logic                  r_ep;
  logic [c_attr_w-1:0]   r_attr;
  logic [LEN_W-1:0]      r_len;
  logic [c_be_w-1:0]     r_first_be;
  logic [c_be_w-1:0]     r_last_be;
  logic [DW_W-1:0]       r_addr_hi;
  logic [DW_W-3:0]       r_addr_lo;

  assign w_accept   = in_valid && in_ready;
  assign w_hdr_last = (r_hdr_idx == (is_4dw(r_fmt) ? 2'd3 : 2'd2));
  assign w_cnt_one  = (r_pl_cnt == c_cnt_one);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // A single-beat TLP can never carry a full header.
          if (!in_sop || in_eop) begin
            w_err = 1'b1;
          end else begin
            w_state_nxt = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (w_accept) begin
          if (w_hdr_last) begin
            w_state_nxt = ST_HOLD;
            w_err       = in_eop && (has_data(r_fmt) || r_td);
          end else if (in_eop) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (hdr_ready) begin
          if (has_data(r_fmt) && !r_eop_seen) begin
            w_state_nxt = ST_PAYLOAD;
          end else if (r_td && !r_eop_seen) begin
            w_state_nxt = ST_DIGEST;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          if (w_cnt_one) begin
            if (in_eop) begin
              w_state_nxt = ST_IDLE;
              w_err       = r_td;
            end else begin
              w_state_nxt = r_td ? ST_DIGEST : ST_DROP;
            end
          end else if (in_eop) begin
            w_state_nxt = ST_IDLE;
            w_err       = 1'b1;
          end
        end
      end
      ST_DIGEST: begin
        if (w_accept) begin
          if (in_eop) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_DROP;
            w_err       = 1'b1;
          end
        end
      end
      ST_DROP: begin
        if (w_accept && in_eop) begin
          w_state_nxt = ST_IDLE;
          w_err       = !r_err_done;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready = r_in_ready;
    pl_valid = 1'b0;
    pl_data  = '0;
    pl_last  = 1'b0;
    if (r_state == ST_PAYLOAD) begin
      in_ready = pl_ready;
      pl_valid = in_valid;
      pl_data  = in_data;
      pl_last  = w_cnt_one || in_eop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready  <= 1'b1;
      r_hdr_valid <= 1'b0;
      r_err       <= 1'b0;
      r_err_done  <= 1'b0;
      r_eop_seen  <= 1'b0;
      r_hdr_idx   <= 2'd0;
      r_pl_cnt    <= '0;
      r_fmt       <= '0;
      r_type      <= '0;
      r_tc        <= '0;
      r_td        <= 1'b0;
      r_ep        <= 1'b0;
      r_attr      <= '0;
      r_len       <= '0;
      r_first_be  <= '0;
      r_last_be   <= '0;
      r_addr_hi   <= '0;
      r_addr_lo   <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt != ST_HOLD);
      r_hdr_valid <= (w_state_nxt == ST_HOLD);
      r_err       <= w_err;

      if (r_state == ST_IDLE && w_accept && in_sop) begin
        r_fmt      <= in_data[c_fmt_msb:c_fmt_lsb];
        r_type     <= in_data[c_type_msb:c_type_lsb];
        r_tc       <= in_data[c_tc_msb:c_tc_lsb];
        r_td       <= in_data[c_td_bit];
        r_ep       <= in_data[c_ep_bit];
        r_attr     <= in_data[c_attr_msb:c_attr_lsb];
        r_len      <= in_data[c_len_lsb +: LEN_W];
        r_first_be <= '0;
        r_last_be  <= '0;
        r_addr_hi  <= '0;
        r_addr_lo  <= '0;
        r_hdr_idx  <= 2'd1;
        r_eop_seen <= 1'b0;
        r_err_done <= 1'b0;
      end

      if (r_state == ST_HDR && w_accept) begin
        r_hdr_idx  <= r_hdr_idx + 2'd1;
        r_eop_seen <= in_eop;
        case (r_hdr_idx)
          2'd1: begin
            r_first_be <= in_data[c_fbe_msb:c_fbe_lsb];
            r_last_be  <= in_data[c_lbe_msb:c_lbe_lsb];
          end
          2'd2: begin
            // DW2 is the upper address for 4DW headers, the only address otherwise.
            if (is_4dw(r_fmt)) begin
              r_addr_hi <= in_data;
            end else begin
              r_addr_lo <= in_data[DW_W-1:2];
            end
          end
          2'd3: begin
            r_addr_lo <= in_data[DW_W-1:2];
          end
          default: begin
          end
        endcase
      end

      if (r_state == ST_HOLD && hdr_ready) begin
        r_pl_cnt <= (r_len == '0) ? c_cnt_max : {1'b0, r_len};
      end else if (r_state == ST_PAYLOAD && w_accept) begin
        r_pl_cnt <= r_pl_cnt - c_cnt_one;
      end

      if (w_err) begin
        r_err_done <= 1'b1;
      end
    end
  end

  assign hdr_valid     = r_hdr_valid;
  assign err_malformed = r_err;
  assign hdr_fmt       = r_fmt;
  assign hdr_type      = r_type;
  assign hdr_tc        = r_tc;
  assign hdr_td        = r_td;
  assign hdr_ep        = r_ep;
  assign hdr_attr      = r_attr;
  assign hdr_len       = r_len;
  assign hdr_first_be  = r_first_be;
  assign hdr_last_be   = r_last_be;
  assign hdr_addr_hi   = r_addr_hi;
  assign hdr_addr_lo   = r_addr_lo;

endmodule
`default_nettype wire

// File: tb/tb_tlp_hdr_capture.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_tlp_hdr_capture : directed self-checking bench for tlp_hdr_capture.    |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module tb_tlp_hdr_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        hdr_valid;
  logic        hdr_ready = 1'b0;
  logic [2:0]  hdr_fmt;
  logic [4:0]  hdr_type;
  logic [2:0]  hdr_tc;
  logic        hdr_td;
  logic        hdr_ep;
  logic [1:0]  hdr_attr;
  logic [9:0]  hdr_len;
  logic [3:0]  hdr_first_be;
  logic [3:0]  hdr_last_be;
  logic [31:0] hdr_addr_hi;
  logic [29:0] hdr_addr_lo;
  logic        pl_valid;
  logic        pl_ready = 1'b1;
  logic [31:0] pl_data;
  logic        pl_last;
  logic        err_malformed;

  int n_checks = 0;
  int n_errors = 0;

  int          mon_pl = 0;
  int          mon_last = 0;
  int          mon_last_at = 0;
  int          mon_err = 0;
  logic [31:0] pl_log [4];

  tlp_hdr_capture #(.DW_W(32), .LEN_W(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sop(in_sop), .in_eop(in_eop),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .hdr_fmt(hdr_fmt), .hdr_type(hdr_type), .hdr_tc(hdr_tc),
    .hdr_td(hdr_td), .hdr_ep(hdr_ep), .hdr_attr(hdr_attr), .hdr_len(hdr_len),
    .hdr_first_be(hdr_first_be), .hdr_last_be(hdr_last_be),
    .hdr_addr_hi(hdr_addr_hi), .hdr_addr_lo(hdr_addr_lo),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data), .pl_last(pl_last),
    .err_malformed(err_malformed)
  );

  always #5 clk = ~clk;

  // Inputs change just after posedge, so the negedge view is what the next edge sees.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_malformed) mon_err++;
      if (pl_valid && pl_ready) begin
        pl_log[mon_pl[1:0]] = pl_data;
        mon_pl++;
        if (pl_last) begin
          mon_last++;
          mon_last_at = mon_pl;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e, input int stall);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    if (stall > 0) begin
      pl_ready = 1'b0;
      repeat (stall) begin
        #1;
        chk("stall_in_ready", in_ready, 1'b0);
        chk("stall_pl_valid", pl_valid, 1'b1);
        @(posedge clk);
        #1;
      end
      pl_ready = 1'b1;
    end
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("send_timeout", n < 50, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic take_hdr();
    hdr_ready = 1'b1;
    @(posedge clk);
    #1;
    hdr_ready = 1'b0;
    chk("hdr_valid_drop", hdr_valid, 1'b0);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b_pl, b_last, b_err;

    // Reset state
    #12;
    chk("rst_hdr_valid", hdr_valid, 1'b0);
    chk("rst_pl_valid", pl_valid, 1'b0);
    chk("rst_pl_last", pl_last, 1'b0);
    chk("rst_err", err_malformed, 1'b0);
    chk("rst_len", hdr_len, 10'd0);
    chk("rst_addr_lo", hdr_addr_lo, 30'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    chk("rst_in_ready", in_ready, 1'b1);

    // 3DW MRd
    b_pl = mon_pl; b_err = mon_err;
    send(32'h0000_0001, 1'b1, 1'b0, 0);
    send(32'h0100_000F, 1'b0, 1'b0, 0);
    chk("mrd_no_hdr_early", hdr_valid, 1'b0);
    send(32'h1000_0000, 1'b0, 1'b1, 0);
    chk("mrd_hdr_valid", hdr_valid, 1'b1);
    chk("mrd_hold_in_ready", in_ready, 1'b0);
    chk("mrd_fmt", hdr_fmt, 3'd0);
    chk("mrd_len", hdr_len, 10'd1);
    chk("mrd_first_be", hdr_first_be, 4'hF);
    chk("mrd_last_be", hdr_last_be, 4'h0);
    chk("mrd_addr_lo", hdr_addr_lo, 30'h0400_0000);
    chk("mrd_addr_hi", hdr_addr_hi, 32'h0);
    take_hdr();
    chk("mrd_idle_in_ready", in_ready, 1'b1);
    idle_cycle();
    chk("mrd_no_pl", mon_pl - b_pl, 0);
    chk("mrd_no_err", mon_err - b_err, 0);

    // 4DW MWr, len 2, td, with payload stalls
    b_pl = mon_pl; b_last = mon_last; b_err = mon_err;
    send(32'h6050_A002, 1'b1, 1'b0, 0);
    send(32'h0000_00FF, 1'b0, 1'b0, 0);
    send(32'h1234_5678, 1'b0, 1'b0, 0);
    send(32'h9ABC_DEF0, 1'b0, 1'b0, 0);
    chk("mwr4_hdr_valid", hdr_valid, 1'b1);
    chk("mwr4_fmt", hdr_fmt, 3'b011);
    chk("mwr4_type", hdr_type, 5'd0);
    chk("mwr4_tc", hdr_tc, 3'd5);
    chk("mwr4_td", hdr_td, 1'b1);
    chk("mwr4_ep", hdr_ep, 1'b0);
    chk("mwr4_attr", hdr_attr, 2'd2);
    chk("mwr4_len", hdr_len, 10'd2);
    chk("mwr4_last_be", hdr_last_be, 4'hF);
    chk("mwr4_addr_hi", hdr_addr_hi, 32'h1234_5678);
    chk("mwr4_addr_lo", hdr_addr_lo, 30'h26AF_37BC);
    take_hdr();
    send(32'hAAAA_0001, 1'b0, 1'b0, 1);
    send(32'hAAAA_0002, 1'b0, 1'b0, 2);
    send(32'hDEAD_BEEF, 1'b0, 1'b1, 0);
    idle_cycle();
    chk("mwr4_pl_beats", mon_pl - b_pl, 2);
    chk("mwr4_pl_last_cnt", mon_last - b_last, 1);
    chk("mwr4_pl_last_pos", mon_last_at - b_pl, 2);
    chk("mwr4_pl0", pl_log[b_pl & 3], 32'hAAAA_0001);
    chk("mwr4_pl1", pl_log[(b_pl + 1) & 3], 32'hAAAA_0002);
    chk("mwr4_no_err", mon_err - b_err, 0);
    chk("mwr4_idle", in_ready, 1'b1);

    // 3DW MWr, len 0 -> 1024 DW
    b_pl = mon_pl; b_last = mon_last; b_err = mon_err;
    send(32'h4000_0000, 1'b1, 1'b0, 0);
    send(32'h0000_000F, 1'b0, 1'b0, 0);
    send(32'h0000_1000, 1'b0, 1'b0, 0);
    chk("mwr1k_len", hdr_len, 10'd0);
    chk("mwr1k_addr_lo", hdr_addr_lo, 30'h400);
    take_hdr();
    for (int i = 0; i < 1024; i++) begin
      send(32'hC000_0000 + i, 1'b0, (i == 1023), 0);
    end
    idle_cycle();
    chk("mwr1k_pl_beats", mon_pl - b_pl, 1024);
    chk("mwr1k_last_cnt", mon_last - b_last, 1);
    chk("mwr1k_last_pos", mon_last_at - b_pl, 1024);
    chk("mwr1k_last_data", pl_log[(b_pl + 1023) & 3], 32'hC000_03FF);
    chk("mwr1k_no_err", mon_err - b_err, 0);
    chk("mwr1k_idle", in_ready, 1'b1);

    // eop on DW1 of a 3DW header, then a clean TLP
    b_err = mon_err;
    send(32'h0000_0001, 1'b1, 1'b0, 0);
    send(32'h0100_000F, 1'b0, 1'b1, 0);
    chk("short_err_pulse", err_malformed, 1'b1);
    chk("short_no_hdr", hdr_valid, 1'b0);
    idle_cycle();
    chk("short_err_one_cycle", err_malformed, 1'b0);
    chk("short_hdr_still_low", hdr_valid, 1'b0);
    send(32'h0000_0003, 1'b1, 1'b0, 0);
    send(32'h0000_00F0, 1'b0, 1'b0, 0);
    send(32'h0000_0044, 1'b0, 1'b1, 0);
    chk("recover_hdr_valid", hdr_valid, 1'b1);
    chk("recover_len", hdr_len, 10'd3);
    chk("recover_first_be", hdr_first_be, 4'h0);
    chk("recover_last_be", hdr_last_be, 4'hF);
    chk("recover_addr_lo", hdr_addr_lo, 30'h11);
    take_hdr();
    idle_cycle();
    chk("short_err_total", mon_err - b_err, 1);

    // len 1 but 3 payload DWs
    b_pl = mon_pl; b_last = mon_last; b_err = mon_err;
    send(32'h4000_0001, 1'b1, 1'b0, 0);
    send(32'h0000_000F, 1'b0, 1'b0, 0);
    send(32'h0000_0100, 1'b0, 1'b0, 0);
    take_hdr();
    send(32'h1111_1111, 1'b0, 1'b0, 0);
    send(32'h2222_2222, 1'b0, 1'b0, 0);
    chk("long_no_err_yet", err_malformed, 1'b0);
    send(32'h3333_3333, 1'b0, 1'b1, 0);
    chk("long_err_at_eop", err_malformed, 1'b1);
    idle_cycle();
    chk("long_pl_beats", mon_pl - b_pl, 1);
    chk("long_last_cnt", mon_last - b_last, 1);
    chk("long_pl_data", pl_log[b_pl & 3], 32'h1111_1111);
    chk("long_err_total", mon_err - b_err, 1);

    // Reset in the middle of a payload
    send(32'h4000_0004, 1'b1, 1'b0, 0);
    send(32'h0000_000F, 1'b0, 1'b0, 0);
    send(32'h0000_0200, 1'b0, 1'b0, 0);
    take_hdr();
    send(32'h5555_0001, 1'b0, 1'b0, 0);
    send(32'h5555_0002, 1'b0, 1'b0, 0);
    send(32'h5555_0003, 1'b0, 1'b0, 0);
    in_valid = 1'b1;
    in_data  = 32'h5555_0004;
    in_eop   = 1'b1;
    #1;
    chk("mid_pl_valid_pre", pl_valid, 1'b1);
    chk("mid_pl_last_pre", pl_last, 1'b1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pl_valid", pl_valid, 1'b0);
    chk("mid_rst_pl_last", pl_last, 1'b0);
    chk("mid_rst_len", hdr_len, 10'd0);
    chk("mid_rst_err", err_malformed, 1'b0);
    in_valid = 1'b0;
    in_eop   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycle();
    b_pl = mon_pl; b_err = mon_err;
    send(32'h5555_0004, 1'b0, 1'b1, 0);
    chk("mid_leftover_err", err_malformed, 1'b1);
    send(32'h0000_0002, 1'b1, 1'b0, 0);
    send(32'h0300_00A5, 1'b0, 1'b0, 0);
    send(32'h8000_0008, 1'b0, 1'b1, 0);
    chk("mid_next_hdr_valid", hdr_valid, 1'b1);
    chk("mid_next_len", hdr_len, 10'd2);
    chk("mid_next_first_be", hdr_first_be, 4'h5);
    chk("mid_next_last_be", hdr_last_be, 4'hA);
    chk("mid_next_addr_lo", hdr_addr_lo, 30'h2000_0002);
    take_hdr();
    idle_cycle();
    chk("mid_no_pl", mon_pl - b_pl, 0);
    chk("mid_err_total", mon_err - b_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
